// File: rtl/softmax_argmax.sv
// softmax_argmax: streaming arg-max over N IEEE-754 binary32 probabilities.
// Element 0 arrives with Start, the rest on consecutive cycles; Done pulses
// one cycle after the last element with the index/value of the largest one.
// NaN elements never win and set the sticky NanSeen flag.
// Optional build macro TOP2_EN adds SecondIndex/SecondValue (runner-up).
module softmax_argmax #(
   parameter int DATALENGTH = 32,
   parameter int INPUTMAX   = 5
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic [DATALENGTH-1:0] Datain,
   input  logic [INPUTMAX-1:0]   N,
   output logic                  Busy,
   output logic                  Done,
   output logic [INPUTMAX-1:0]   MaxIndex,
   output logic [DATALENGTH-1:0] MaxValue,
`ifdef TOP2_EN
   output logic [INPUTMAX-1:0]   SecondIndex,
   output logic [DATALENGTH-1:0] SecondValue,
`endif
   output logic                  NanSeen
);

   localparam logic [DATALENGTH-1:0] NAN_CANON = DATALENGTH'(32'h7fc00000);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [INPUTMAX-1:0]   count_q, count_d;
   logic [INPUTMAX-1:0]   n_q, n_d;
   logic [INPUTMAX-1:0]   max_idx_q, max_idx_d;
   logic [DATALENGTH-1:0] max_val_q, max_val_d;
   logic                  have_q, have_d;      // a non-NaN element is held as max
   logic                  nan_q, nan_d;
`ifdef TOP2_EN
   logic [INPUTMAX-1:0]   sec_idx_q, sec_idx_d;
   logic [DATALENGTH-1:0] sec_val_q, sec_val_d;
   logic                  have2_q, have2_d;    // a runner-up has been recorded
`endif
   logic                  elem_nan;

   // Exponent all ones with a non-zero mantissa.
   function automatic logic is_nan(input logic [DATALENGTH-1:0] x);
      return (&x[DATALENGTH-2:DATALENGTH-9]) && (|x[DATALENGTH-10:0]);
   endfunction

   // Strict a > b for non-NaN operands; +0 and -0 are equal.
   function automatic logic fp_gt(input logic [DATALENGTH-1:0] a,
                                  input logic [DATALENGTH-1:0] b);
      logic a_s, b_s;
      logic [DATALENGTH-2:0] a_m, b_m;
      a_s = a[DATALENGTH-1];
      b_s = b[DATALENGTH-1];
      a_m = a[DATALENGTH-2:0];
      b_m = b[DATALENGTH-2:0];
      if (a_s != b_s)
         return !((a_m == '0) && (b_m == '0)) && !a_s;
      else if (!a_s)
         return a_m > b_m;
      else
         return a_m < b_m;
   endfunction

   assign elem_nan = is_nan(Datain);

   // Next-state: vector start/restart, element accumulation, done pulse.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      n_d       = n_q;
      max_idx_d = max_idx_q;
      max_val_d = max_val_q;
      have_d    = have_q;
      nan_d     = nan_q;
`ifdef TOP2_EN
      sec_idx_d = sec_idx_q;
      sec_val_d = sec_val_q;
      have2_d   = have2_q;
`endif
      if (Start) begin
         // Any state: begin a new vector; Datain is element 0.
         n_d       = N;
         count_d   = INPUTMAX'(1);
         max_idx_d = '0;
         max_val_d = '0;
         have_d    = 1'b0;
         nan_d     = 1'b0;
`ifdef TOP2_EN
         sec_idx_d = '0;
         sec_val_d = '0;
         have2_d   = 1'b0;
`endif
         if (N == '0) begin
            state_d = S_DONE;
         end else begin
            if (elem_nan) begin
               nan_d     = 1'b1;
               max_val_d = NAN_CANON;
            end else begin
               max_val_d = Datain;
               have_d    = 1'b1;
            end
            state_d = (N == INPUTMAX'(1)) ? S_DONE : S_COLLECT;
         end
      end else begin
         case (state_q)
            S_COLLECT: begin
               count_d = count_q + INPUTMAX'(1);
               if (elem_nan) begin
                  nan_d = 1'b1;
               end else if (!have_q || fp_gt(Datain, max_val_q)) begin
`ifdef TOP2_EN
                  // Only a real previous max shifts down to runner-up.
                  if (have_q) begin
                     sec_idx_d = max_idx_q;
                     sec_val_d = max_val_q;
                     have2_d   = 1'b1;
                  end
`endif
                  max_idx_d = count_q;
                  max_val_d = Datain;
                  have_d    = 1'b1;
               end
`ifdef TOP2_EN
               else if (!have2_q || fp_gt(Datain, sec_val_q)) begin
                  sec_idx_d = count_q;
                  sec_val_d = Datain;
                  have2_d   = 1'b1;
               end
`endif
               if (count_q == n_q - INPUTMAX'(1))
                  state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and result registers; async reset returns everything to idle/zero.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         n_q       <= '0;
         max_idx_q <= '0;
         max_val_q <= '0;
         have_q    <= 1'b0;
         nan_q     <= 1'b0;
`ifdef TOP2_EN
         sec_idx_q <= '0;
         sec_val_q <= '0;
         have2_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         n_q       <= n_d;
         max_idx_q <= max_idx_d;
         max_val_q <= max_val_d;
         have_q    <= have_d;
         nan_q     <= nan_d;
`ifdef TOP2_EN
         sec_idx_q <= sec_idx_d;
         sec_val_q <= sec_val_d;
         have2_q   <= have2_d;
`endif
      end
   end

   assign Busy     = (state_q == S_COLLECT);
   assign Done     = (state_q == S_DONE);
   assign MaxIndex = max_idx_q;
   assign MaxValue = max_val_q;
   assign NanSeen  = nan_q;
`ifdef TOP2_EN
   assign SecondIndex = sec_idx_q;
   assign SecondValue = sec_val_q;
`endif

endmodule
